sprite_mem_arbiter: RTL and testbench

SPRITE_MEM_ARBITER -- requirements
Module: sprite_mem_arbiter

---
 rtl/sprite_pkg.sv | 11 +
 rtl/rr_arb_core.sv | 28 ++
 rtl/sprite_mem_arbiter.sv | 87 ++++++++
 tb/tb_sprite_mem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared constants for the sprite memory arbiter: requester indices and the
// RGB444 transparent colour.
package sprite_pkg;

  localparam int unsigned REQ_ROBOT = 0;
  localparam int unsigned REQ_ENEMY = 1;
  localparam int unsigned REQ_HUD   = 2;

  localparam logic [11:0] TRANSPARENT_RGB = 12'h000;

endpackage

// File: rtl/rr_arb_core.sv
// Rotating-priority grant: the search starts one past last_grant, and the first
// valid requester found gets a one-hot grant.
module rr_arb_core #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one sprite RAM read port among NUM_REQ icon
// fetchers; read data is routed back through a RAM_LAT-deep tag pipeline.
module sprite_mem_arbiter
  import sprite_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned RAM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      ram_en,
  output logic [ADDR_W-1:0]         ram_addr,
  input  logic [DATA_W-1:0]         ram_q,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int unsigned IDX_W = (NUM_REQ > 2) ? 2 : 1;

  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] accept;

  logic [RAM_LAT-1:0] tag_vld;
  logic [NUM_REQ-1:0] tag_id [RAM_LAT];

  rr_arb_core #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arb_core (
    .valid      (req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign req_ready = reset ? '0 : grant;
  assign accept    = req_valid & req_ready;
  assign ram_en    = |accept;

  always_comb begin
    ram_addr  = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept[i]) begin
        ram_addr  = req_addr[i*ADDR_W +: ADDR_W];
        grant_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (ram_en) begin
      last_grant <= grant_idx;
    end
  end

  // Stage 0 holds the tag of the read issued this cycle; the last stage lines up with ram_q.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_vld <= '0;
      for (int unsigned s = 0; s < RAM_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_vld[0] <= ram_en;
      tag_id[0]  <= accept;
      for (int unsigned s = 1; s < RAM_LAT; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_id[s]  <= tag_id[s-1];
      end
    end
  end

  assign rsp_valid = tag_vld[RAM_LAT-1] ? tag_id[RAM_LAT-1] : '0;
  assign rsp_data  = (|rsp_valid) ? ram_q : DATA_W'(TRANSPARENT_RGB);
  assign busy      = |tag_vld;

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Bench for sprite_mem_arbiter: two instances (RAM_LAT 1 and 2) against a
// cycle-history reference model, plus directed literal scenarios.
module tb_sprite_mem_arbiter;

  localparam int N     = 3;
  localparam int AW    = 16;
  localparam int DW    = 12;
  localparam int HMAX  = 12000;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;

  logic [N-1:0]   ready1, ready2, rsp1, rsp2;
  logic           en1, en2, busy1, busy2;
  logic [AW-1:0]  addr1, addr2;
  logic [DW-1:0]  q1, q2, q2a, data1, data2;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int max_wait = 0;

  always #5 clk = ~clk;

  sprite_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready1), .ram_en(en1), .ram_addr(addr1), .ram_q(q1),
    .rsp_valid(rsp1), .rsp_data(data1), .busy(busy1));

  sprite_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RAM_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(ready2), .ram_en(en2), .ram_addr(addr2), .ram_q(q2),
    .rsp_valid(rsp2), .rsp_data(data2), .busy(busy2));

  function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
    return DW'(a * 16'd13 + 16'd7);
  endfunction

  // Sprite RAM contents are a fixed function of the address.
  always @(posedge clk) begin
    q1  <= ram_word(addr1);
    q2a <= ram_word(addr2);
    q2  <= q2a;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: per-cycle history of accepts and resets.
  logic [N-1:0]  acc_id   [HMAX];
  logic [AW-1:0] acc_addr [HMAX];
  logic          rst_hist [HMAX];
  int            ptr = N - 1;
  int            waits [N];

  function automatic bit reset_in(input int lo, input int hi);
    for (int x = lo; x <= hi; x++) if (x >= 0 && rst_hist[x]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic exp_rsp(input int lat, input int c, output logic [N-1:0] id,
                         output logic [DW-1:0] d, output logic b);
    id = '0; d = '0; b = 1'b0;
    for (int a = c - lat; a < c; a++) begin
      if (a >= 0 && acc_id[a] != '0 && !reset_in(a + 1, c - 1)) begin
        b = 1'b1;
        if (a == c - lat) begin
          id = acc_id[a];
          d  = ram_word(acc_addr[a]);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0]  eg, eid;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eb;
    int            gi;
    eg = '0; ea = '0; gi = -1;
    if (!reset) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (gi < 0 && req_valid[idx]) gi = idx;
      end
    end
    if (gi >= 0) begin
      eg[gi] = 1'b1;
      ea = req_addr[gi*AW +: AW];
    end
    if (cyc < HMAX) begin
      acc_id[cyc]   = eg;
      acc_addr[cyc] = ea;
      rst_hist[cyc] = reset;
    end
    if (cyc >= 1 && cyc < HMAX) begin
      chk("ready_l1", 32'(ready1), 32'(eg));
      chk("ready_l2", 32'(ready2), 32'(eg));
      chk("ram_en_l1", 32'(en1), 32'(gi >= 0));
      chk("ram_en_l2", 32'(en2), 32'(gi >= 0));
      chk("ram_addr_l1", 32'(addr1), 32'(ea));
      chk("ram_addr_l2", 32'(addr2), 32'(ea));
      exp_rsp(1, cyc, eid, ed, eb);
      chk("rsp_valid_l1", 32'(rsp1), 32'(eid));
      chk("rsp_data_l1", 32'(data1), 32'(ed));
      chk("busy_l1", 32'(busy1), 32'(eb));
      exp_rsp(2, cyc, eid, ed, eb);
      chk("rsp_valid_l2", 32'(rsp2), 32'(eid));
      chk("rsp_data_l2", 32'(data2), 32'(ed));
      chk("busy_l2", 32'(busy2), 32'(eb));
    end
    for (int i = 0; i < N; i++) begin
      if (!reset && req_valid[i] && !ready1[i]) waits[i]++;
      else waits[i] = 0;
      if (waits[i] > max_wait) max_wait = waits[i];
    end
    if (reset) ptr = N - 1;
    else if (gi >= 0) ptr = gi;
    cyc++;
  end

  task automatic step(input logic [N-1:0] v, input logic [N*AW-1:0] a, input logic r);
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    reset     = r;
    @(negedge clk);
  endtask

  function automatic logic [N*AW-1:0] pack(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                           input logic [AW-1:0] a2);
    return {a2, a1, a0};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) waits[i] = 0;
    step('0, '0, 1'b1);
    step('0, '0, 1'b1);
    chk("reset_busy_l1", 32'(busy1), 32'd0);
    chk("reset_rsp_l2", 32'(rsp2), 32'd0);
    chk("reset_data_l1", 32'(data1), 32'd0);

    // All three contend: rotation 0,1,2,0,1,2
    for (int k = 0; k < 6; k++) begin
      step(3'b111, pack(16'h0010, 16'h0020, 16'h0030), 1'b0);
      chk("s1_grant", 32'(ready1), 32'(3'b001 << (k % 3)));
      if (k > 0) chk("s1_rsp", 32'(rsp1), 32'(3'b001 << ((k - 1) % 3)));
    end
    step('0, '0, 1'b0);
    chk("s1_rsp_last", 32'(rsp1), 32'h4);

    // Lone requester 1 streaming addresses 10..13
    for (int k = 0; k < 4; k++) begin
      step(3'b010, pack(16'h0, 16'(10 + k), 16'h0), 1'b0);
      chk("s2_ram_addr", 32'(addr1), 32'(10 + k));
      if (k > 0) chk("s2_rsp", 32'(rsp1), 32'h2);
    end
    step('0, '0, 1'b0);
    chk("s2_rsp_last", 32'(rsp1), 32'h2);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Single HUD fetch through the two-cycle RAM
    step(3'b100, pack(16'h0, 16'h0, 16'h0100), 1'b0);
    chk("s3_grant", 32'(ready2), 32'h4);
    chk("s3_busy0", 32'(busy2), 32'd0);
    step('0, '0, 1'b0);
    chk("s3_busy1", 32'(busy2), 32'd1);
    chk("s3_rsp1", 32'(rsp2), 32'd0);
    step('0, '0, 1'b0);
    chk("s3_busy2", 32'(busy2), 32'd1);
    chk("s3_rsp2", 32'(rsp2), 32'h4);
    chk("s3_data", 32'(data2), 32'(ram_word(16'h0100)));
    step('0, '0, 1'b0);
    chk("s3_busy3", 32'(busy2), 32'd0);
    chk("s3_rsp3", 32'(rsp2), 32'd0);

    // Requester 2 pulses between grants to requester 0
    step(3'b001, pack(16'h0005, 16'h0, 16'h0006), 1'b0);
    chk("s4_g0", 32'(ready1), 32'h1);
    step(3'b101, pack(16'h0005, 16'h0, 16'h0006), 1'b0);
    chk("s4_g2", 32'(ready1), 32'h4);
    step(3'b001, pack(16'h0005, 16'h0, 16'h0006), 1'b0);
    chk("s4_g0b", 32'(ready1), 32'h1);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);

    // Reset one cycle after an accept discards the two-cycle response
    step(3'b100, pack(16'h0, 16'h0, 16'h0200), 1'b0);
    chk("s5_grant", 32'(ready2), 32'h4);
    step(3'b111, pack(16'h1, 16'h2, 16'h3), 1'b1);
    chk("s5_ready_in_reset", 32'(ready2), 32'd0);
    chk("s5_en_in_reset", 32'(en2), 32'd0);
    step('0, '0, 1'b0);
    chk("s5_no_rsp", 32'(rsp2), 32'd0);
    chk("s5_busy_after", 32'(busy2), 32'd0);

    // Randomised traffic
    for (int k = 0; k < 10000; k++) begin
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = ($urandom_range(3, 0) != 0);
      step(v, {16'($urandom), 16'($urandom), 16'($urandom)}, ($urandom_range(499, 0) == 0));
    end
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    step('0, '0, 1'b0);
    chk("max_wait_le_2", 32'(max_wait <= N - 1), 32'd1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
